// File: rtl/iir_output_conditioner.sv
// Rounds, shifts and saturates 32-bit IIR results to 16 bits, decimates, and buffers them in a show-ahead FIFO.
// Latency: sample accepted at edge t is written to the FIFO at edge t+2; out_valid is seen after that edge.
// Backpressure: none toward the filter; when the FIFO is full, kept samples are dropped and counted in drop_count.
module iir_output_conditioner #(
   parameter int SHIFT      = 15,
   parameter int DECIM      = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [31:0] in_data,
   input  logic               in_valid,
   output logic signed [15:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic        [15:0] sat_count,
   output logic        [15:0] drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = 5;
   localparam logic signed [32:0] RND     = 33'sd1 <<< (SHIFT - 1);
   localparam logic signed [32:0] SAT_MAX = 33'sd32767;
   localparam logic signed [32:0] SAT_MIN = -33'sd32768;

   // stage 1: rounded sum plus the keep decision taken at acceptance
   logic                 s1_vld;
   logic                 s1_keep;
   logic signed [32:0]   s1_sum;
   logic        [DW-1:0] dec_cnt;

   // stage 2: clamped sample waiting for its FIFO write
   logic                 s2_vld;
   logic signed [15:0]   s2_dat;

   // FIFO storage and bookkeeping
   logic signed [15:0]   mem [FIFO_DEPTH];
   logic        [AW-1:0] wr_ptr;
   logic        [AW-1:0] rd_ptr;
   logic        [CW-1:0] occ;

   logic signed [32:0]   shifted;
   logic signed [15:0]   clamp_dat;
   logic                 sat;
   logic                 s1_fwd;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 wr_en;
   logic                 drop;

   // Stage 1 register; data only loads on a new sample so idle cycles leave it untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_keep <= 1'b0;
         s1_sum  <= '0;
         dec_cnt <= '0;
      end else begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_sum  <= {in_data[31], in_data} + RND;
            s1_keep <= (dec_cnt == '0);
            if (dec_cnt == DW'(DECIM - 1)) begin
               dec_cnt <= '0;
            end else begin
               dec_cnt <= dec_cnt + DW'(1);
            end
         end
      end
   end

   // Shift and clamp the rounded sum; flag when the clamp alters the value
   always_comb begin
      shifted   = s1_sum >>> SHIFT;
      clamp_dat = shifted[15:0];
      sat       = 1'b0;
      if (shifted > SAT_MAX) begin
         clamp_dat = 16'sh7FFF;
         sat       = 1'b1;
      end else if (shifted < SAT_MIN) begin
         clamp_dat = -16'sh8000;
         sat       = 1'b1;
      end
   end

   assign s1_fwd = s1_vld & s1_keep;

   // Stage 2 register and saturation counter; discarded samples never reach here
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld    <= 1'b0;
         s2_dat    <= '0;
         sat_count <= '0;
      end else begin
         s2_vld <= s1_fwd;
         if (s1_fwd) begin
            s2_dat <= clamp_dat;
            if (sat && (sat_count != 16'hFFFF)) begin
               sat_count <= sat_count + 16'd1;
            end
         end
      end
   end

   // A write into a full FIFO still succeeds when a pop frees a slot on the same edge
   always_comb begin
      full  = (occ == CW'(FIFO_DEPTH));
      push  = s2_vld;
      pop   = out_valid & out_ready;
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;
   end

   // FIFO storage; contents need no reset since out_data is gated by out_valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= s2_dat;
      end
   end

   // FIFO pointers, occupancy and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         drop_count <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !pop) begin
            occ <= occ + CW'(1);
         end else if (pop && !wr_en) begin
            occ <= occ - CW'(1);
         end
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   // Show-ahead read; a write into an empty FIFO becomes visible only on the next cycle
   always_comb begin
      out_valid = (occ != '0);
      out_data  = out_valid ? mem[rd_ptr] : 16'sd0;
   end

endmodule

// File: tb/tb_iir_output_conditioner.sv
// Scoreboard bench: expected samples are queued when driven and compared as the DUTs pop them.
// Two instances: DECIM=1 for rounding/saturation/FIFO/reset scenarios, DECIM=4 for decimation.
// All comparisons go through chk; the final line reports totals.
module tb_iir_output_conditioner;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [31:0] in_data;
   logic               in_valid;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic        [15:0] sat_count;
   logic        [15:0] drop_count;

   logic signed [31:0] in_data4;
   logic               in_valid4;
   logic signed [15:0] out_data4;
   logic               out_valid4;
   logic               out_ready4;
   logic        [15:0] sat_count4;
   logic        [15:0] drop_count4;

   int n_tests = 0;
   int n_fail  = 0;
   int q[$];
   int q4[$];

   iir_output_conditioner #(.SHIFT(15), .DECIM(1), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sat_count(sat_count), .drop_count(drop_count)
   );

   iir_output_conditioner #(.SHIFT(15), .DECIM(4), .FIFO_DEPTH(8)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
      .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sat_count(sat_count4), .drop_count(drop_count4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: floor((x + 2^14) / 2^15) with explicit floor division, then clamp
   function automatic int model(input int x);
      longint n;
      longint r;
      n = longint'(x) + 64'sd16384;
      r = n / 64'sd32768;
      if ((n % 64'sd32768) != 0 && n < 0) r = r - 1;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input bit push);
      in_data  = x;
      in_valid = 1'b1;
      if (push) q.push_back(model(x));
      step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || q4.size() != 0) && n < 200) begin
         step();
         n++;
      end
      chk("drain_left", q.size() + q4.size(), 0);
      step();
      step();
      chk("drain_out_valid", int'(out_valid), 0);
      chk("drain_out_valid4", int'(out_valid4), 0);
   endtask

   initial begin
      rst        = 1'b1;
      in_data    = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_data4   = '0;
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               if (q.size() == 0) chk("out_unexpected", int'(out_valid), 0);
               else chk("out_data", int'(out_data), q.pop_front());
            end
            if (!rst && out_valid4 && out_ready4) begin
               if (q4.size() == 0) chk("out4_unexpected", int'(out_valid4), 0);
               else chk("out4_data", int'(out_data4), q4.pop_front());
            end
         end
      join_none

      // reset state
      step();
      step();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_sat", int'(sat_count), 0);
      chk("rst_drop", int'(drop_count), 0);
      chk("rst_out_valid4", int'(out_valid4), 0);
      rst = 1'b0;
      step();

      // rounding ties and latency
      out_ready = 1'b1;
      begin
         int vals[4];
         vals = '{32'h00004000, 32'h00003FFF, 32'hFFFFC000, 32'hFFFFBFFF};
         for (int i = 0; i < 4; i++) begin
            send(vals[i], 1'b1);
            if (i == 1) chk("lat_before_t2", int'(out_valid), 0);
            if (i == 2) chk("lat_at_t2", int'(out_valid), 1);
         end
      end
      in_valid = 1'b0;
      drain();

      // saturation
      send(32'h3FFFFFFF, 1'b1);
      send(32'h80000000, 1'b1);
      in_valid = 1'b0;
      drain();
      chk("sat_two", int'(sat_count), 2);
      send(32'h3FFF0000, 1'b1);
      in_valid = 1'b0;
      drain();
      chk("sat_still_two", int'(sat_count), 2);

      // full FIFO with drops
      out_ready = 1'b0;
      for (int v = 1; v <= 10; v++) send(v <<< 15, v <= 8);
      in_valid = 1'b0;
      repeat (3) step();
      chk("full_drop", int'(drop_count), 2);
      chk("full_out_valid", int'(out_valid), 1);
      chk("full_head", int'(out_data), 1);
      repeat (3) step();
      chk("full_head_hold", int'(out_data), 1);
      out_ready = 1'b1;
      drain();

      // full FIFO, write and pop on the same edge
      out_ready = 1'b0;
      for (int v = 11; v <= 18; v++) send(v <<< 15, 1'b1);
      in_valid = 1'b0;
      repeat (3) step();
      send(19 <<< 15, 1'b1);
      in_valid = 1'b0;
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      step();
      chk("simul_drop", int'(drop_count), 2);
      chk("simul_head", int'(out_data), 12);
      out_ready = 1'b1;
      drain();

      // reset with 5 buffered and 2 in flight
      out_ready = 1'b0;
      for (int v = 1; v <= 7; v++) send(v <<< 15, 1'b1);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      q.delete();
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_sat", int'(sat_count), 0);
      chk("mid_rst_drop", int'(drop_count), 0);
      step();
      step();
      chk("mid_rst_flush", int'(out_valid), 0);
      send(5 <<< 15, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // decimation by 4, back-to-back then every other cycle
      for (int v = 0; v < 12; v++) begin
         in_data4  = v <<< 15;
         in_valid4 = 1'b1;
         if (v % 4 == 0) q4.push_back(v);
         step();
      end
      in_valid4 = 1'b0;
      drain();
      for (int v = 0; v < 12; v++) begin
         in_data4  = v <<< 15;
         in_valid4 = 1'b1;
         if (v % 4 == 0) q4.push_back(v);
         step();
         in_valid4 = 1'b0;
         step();
      end
      drain();
      chk("dec_drop", int'(drop_count4), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iir_output_conditioner.md
IIR_OUTPUT_CONDITIONER -- requirements
Module: iir_output_conditioner

Interface
REQ-001 SHALL have parameter SHIFT, default 15: arithmetic right-shift applied to the 32-bit filter result; legal range 1..16.
REQ-002 SHALL have parameter DECIM, default 1: keep one sample in every DECIM accepted samples; legal range 1..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries; power of two, 2..64.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_data, input, 32 bits, signed: the IIR filter data_out.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is a new sample this cycle; there is no backpressure to the filter.
REQ-008 SHALL have port out_data, output, 16 bits, signed: head-of-FIFO sample.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data; a pop occurs when out_valid and out_ready are both high.
REQ-011 SHALL have port sat_count, output, 16 bits: number of saturated samples; the count saturates at 0xFFFF.
REQ-012 SHALL have port drop_count, output, 16 bits: number of kept samples lost to a full FIFO; the count saturates at 0xFFFF.

Function
REQ-013 Stage 1 SHALL, at the edge where in_valid=1, register the 33-bit sign-extended sum in_data + 2^(SHIFT-1).
REQ-014 Stage 2 SHALL, one edge later, register the sum arithmetic-shifted right by SHIFT and then clamped to [-32768, 32767].
- Rounding is round-half-up, i.e. toward +infinity at ties.
REQ-015 Stage 2 SHALL raise an internal sat flag when the clamp changes the value; sat_count increments by 1 for each such sample.
- Saturation counting applies only to kept samples.
REQ-016 A decimation counter SHALL count accepted samples.
- Range is 0..DECIM-1; it wraps to 0 after DECIM-1.
- A sample is kept only when the counter is 0 at its acceptance; other samples are discarded after stage 1 and never affect the counters.
REQ-017 The kept stage-2 sample SHALL be written to the FIFO at the following edge.
- Timing: in_valid is sampled at edge t, the FIFO write happens at edge t+2, and out_valid is high after edge t+2 when the FIFO was empty.
REQ-018 The pipeline SHALL accept one sample per clock with no bubbles; valid bits travel with the data through each stage.
REQ-019 The FIFO SHALL be show-ahead: out_data equals the oldest entry whenever out_valid=1.
- out_data is held stable while out_valid=1 and out_ready=0.
REQ-020 A write when the FIFO is full with no simultaneous pop SHALL discard the sample and increment drop_count.
- FIFO contents are unchanged.
REQ-021 A simultaneous write and pop when full SHALL both occur: occupancy stays at FIFO_DEPTH and there is no drop.
REQ-022 A pop when the FIFO is empty SHALL have no effect.
- A write and a pop in the same cycle with the FIFO empty SHALL NOT pass data through combinationally; out_valid rises the next cycle.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
- Occupancy SHALL be tracked with a counter of width log2(FIFO_DEPTH)+1.
REQ-024 in_valid=0 SHALL hold all pipeline data and counters except for FIFO pops.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL clear:
- pipeline valids and data;
- the decimation counter;
- FIFO pointers and occupancy;
- sat_count and drop_count.
REQ-026 Outputs SHALL read out_valid=0, out_data=0, sat_count=0 and drop_count=0 from the first edge with rst=1.
- rst asserted mid-stream SHALL discard all in-flight and buffered samples.
REQ-027 The first in_valid sampled at an edge with rst=0 after reset SHALL be kept, since the decimation counter is 0.

Verification
REQ-028 Rounding, SHIFT=15, DECIM=1, out_ready=1:
- inputs 0x00004000, 0x00003FFF, 0xFFFFC000, 0xFFFFBFFF -> out_data 1, 0, 0, -1 in order;
- first out_valid is high after edge t+2.
REQ-029 Saturation:
- inputs 0x3FFFFFFF and 0x80000000 -> out_data 32767 and -32768, sat_count=2;
- input 0x3FFF0000 -> 32766, sat_count stays 2.
REQ-030 Full FIFO, FIFO_DEPTH=8, out_ready=0: 10 consecutive valid samples 1..10 (shifted values) -> 8 entries holding 1..8 and drop_count=2. Then out_ready=1 -> pops 1..8 in order, then out_valid=0.
REQ-031 Decimation, DECIM=4: 12 consecutive samples with values 0..11 -> output stream 0, 4, 8.
- With in_valid toggled every other cycle, the same three values result.
REQ-032 Full FIFO with a simultaneous pop: the FIFO is held full, then a write and a pop occur in the same cycle -> drop_count unchanged and occupancy stays 8.
REQ-033 Reset mid-operation: rst=1 for one cycle with 5 entries buffered and 2 samples in the pipeline -> next cycle out_valid=0 and both counters 0; the next input produces exactly one output, kept.
